// File: rtl/line_tap_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_tap_buffer
// Purpose  : Multi-line video buffer for vertical-window filters. For every
//            input pixel it emits a column of TAPS vertically aligned pixels:
//            the current pixel plus the pixels at the same column in the
//            TAPS-1 previous lines. A ring of TAPS-1 read-first line RAMs
//            holds the history.
// Ports    : clk       - single clock
//            rst_n     - synchronous active-low reset
//            line_len  - active pixels per line (sampled on sof / in reset)
//            sof       - start of frame, restarts column and line counting
//            in_valid  - in_data valid
//            in_data   - input pixel
//            out_valid - out_data valid
//            out_data  - tap k at [k*DATA_WIDTH +: DATA_WIDTH], k=0 current
//            out_full  - every tap of out_data holds a real line
//            line_done - marks the last pixel of a line
//            len_err   - sticky illegal line length flag
// Revision : 1.0 - initial release
// ============================================================================
module line_tap_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 11,
    parameter int TAPS       = 3,
    parameter int OUTPUT_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH:0]        line_len,
    input  logic                       sof,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    output logic [TAPS*DATA_WIDTH-1:0] out_data,
    output logic                       out_full,
    output logic                       line_done,
    output logic                       len_err
);

    localparam int c_NB    = TAPS - 1;
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_WBW   = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_SW    = c_WBW + 1;
    localparam int c_LCW   = $clog2(TAPS);

    localparam logic [ADDR_WIDTH:0]   c_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_COL_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_WBW-1:0]      c_WB_ONE  = c_WBW'(1);
    localparam logic [c_WBW-1:0]      c_WB_LAST = c_WBW'(c_NB - 1);
    localparam logic [c_LCW-1:0]      c_LC_ONE  = c_LCW'(1);
    localparam logic [c_LCW-1:0]      c_LC_MAX  = c_LCW'(TAPS - 1);

    // ------------------------------------------------------------------
    // Frame / line state
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_col;
    logic [c_WBW-1:0]      r_wb;
    logic [c_LCW-1:0]      r_lc;
    logic [ADDR_WIDTH:0]   r_len_q;
    logic                  r_len_err;

    logic                  w_len_ok;
    logic [ADDR_WIDTH:0]   w_len_sampled;
    logic [ADDR_WIDTH-1:0] w_col;
    logic [c_WBW-1:0]      w_wb;
    logic [c_LCW-1:0]      w_lc;
    logic [ADDR_WIDTH:0]   w_len;
    logic [ADDR_WIDTH:0]   w_last;
    logic                  w_eol;

    // An illegal length is replaced by the longest line the RAMs can hold.
    assign w_len_ok      = (line_len != '0) && (line_len <= c_MAX_LEN);
    assign w_len_sampled = w_len_ok ? line_len : c_MAX_LEN;

    // Effective state for this cycle: sof takes effect before a coincident
    // pixel, so that pixel becomes column 0 of line 0 of the new frame.
    always_comb begin
        w_col = r_col;
        w_wb  = r_wb;
        w_lc  = r_lc;
        w_len = r_len_q;
        if (sof) begin
            w_col = '0;
            w_wb  = '0;
            w_lc  = '0;
            w_len = w_len_sampled;
        end
    end

    assign w_last = w_len - c_LEN_ONE;
    assign w_eol  = ({1'b0, w_col} == w_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_wb      <= '0;
            r_lc      <= '0;
            r_len_q   <= w_len_sampled;
            r_len_err <= 1'b0;
        end else begin
            if (sof) begin
                r_len_err <= !w_len_ok;
            end
            r_len_q <= w_len;
            if (in_valid && w_eol) begin
                r_col <= '0;
                r_wb  <= (w_wb == c_WB_LAST) ? '0 : (w_wb + c_WB_ONE);
                r_lc  <= (w_lc == c_LC_MAX) ? w_lc : (w_lc + c_LC_ONE);
            end else if (in_valid) begin
                r_col <= w_col + c_COL_ONE;
                r_wb  <= w_wb;
                r_lc  <= w_lc;
            end else begin
                r_col <= w_col;
                r_wb  <= w_wb;
                r_lc  <= w_lc;
            end
        end
    end

    assign len_err = r_len_err;

    // ------------------------------------------------------------------
    // Line RAM ring. Non-blocking read and write of the same word give
    // read-first behaviour, so the bank being overwritten still returns
    // the oldest line. Contents are never cleared; masking hides them.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [c_NB][c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd  [c_NB];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int b = 0; b < c_NB; b++) begin
                r_rd[b] <= r_mem[b][w_col];
                if (w_wb == c_WBW'(b)) begin
                    r_mem[b][w_col] <= in_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: pixel, bank pointer and line count travel with the RAM read.
    // Tap and bank fields only load on a valid pixel so out_data holds.
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    logic                  r_s1_eol;
    logic                  r_s1_full;
    logic [DATA_WIDTH-1:0] r_s1_tap0;
    logic [c_WBW-1:0]      r_s1_wb;
    logic [c_LCW-1:0]      r_s1_lc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_full  <= 1'b0;
            r_s1_tap0  <= '0;
            r_s1_wb    <= '0;
            r_s1_lc    <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_eol   <= in_valid & w_eol;
            r_s1_full  <= in_valid & (w_lc == c_LC_MAX);
            if (in_valid) begin
                r_s1_tap0 <= in_data;
                r_s1_wb   <= w_wb;
                r_s1_lc   <= w_lc;
            end
        end
    end

    logic [TAPS*DATA_WIDTH-1:0] w_s1_data;

    assign w_s1_data[0 +: DATA_WIDTH] = r_s1_tap0;

    // Tap k comes from bank (wb - k) mod (TAPS-1), computed without a
    // modulo operator as wb + (TAPS-1-k) with one conditional wrap.
    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        logic [c_SW-1:0]  w_sum;
        logic [c_WBW-1:0] w_sel;

        assign w_sum = {1'b0, r_s1_wb} + c_SW'(c_NB - k);
        assign w_sel = (w_sum >= c_SW'(c_NB)) ? c_WBW'(w_sum - c_SW'(c_NB))
                                              : c_WBW'(w_sum);
        assign w_s1_data[k*DATA_WIDTH +: DATA_WIDTH] =
            (r_s1_lc >= c_LCW'(k)) ? r_rd[w_sel] : '0;
    end

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    if (OUTPUT_REG != 0) begin : g_oreg
        logic                       r_s2_valid;
        logic                       r_s2_eol;
        logic                       r_s2_full;
        logic [TAPS*DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_eol   <= 1'b0;
                r_s2_full  <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_eol   <= r_s1_eol;
                r_s2_full  <= r_s1_full;
                if (r_s1_valid) begin
                    r_s2_data <= w_s1_data;
                end
            end
        end

        assign out_valid = r_s2_valid;
        assign out_data  = r_s2_data;
        assign out_full  = r_s2_full;
        assign line_done = r_s2_eol;
    end else begin : g_noreg
        assign out_valid = r_s1_valid;
        assign out_data  = w_s1_data;
        assign out_full  = r_s1_full;
        assign line_done = r_s1_eol;
    end

endmodule
`default_nettype wire
